burst_sram_bridge: RTL and testbench

Responder for the burst-RAM command interface (`br_` prefix) used between `Cache` and external memory. It accepts single-command read/write bursts from an initiator and serves them from a simple single-port synchronous SRAM (BSRAM) with byte write enables and 1-cycle read latency. This lets the cache run against on-chip block RAM with the same protocol it uses against the DDR controller.

---
 rtl/burst_sram_bridge.sv | 133 +++++++++++++
 tb/tb_burst_sram_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_sram_bridge.sv
// Burst-RAM command responder serving read/write bursts from a 1-cycle-latency byte-enable SRAM.
// Define BURST_SRAM_BRIDGE_LATENCY_PAD_EN to stretch read latency to CYCLES_BEFORE_DATA_READY.
module burst_sram_bridge #(
    parameter int DATA_BITWIDTH            = 64,
    parameter int DEPTH_BITWIDTH           = 8,
    parameter int BURST_COUNT              = 4,
    parameter int CYCLES_BEFORE_DATA_READY = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd,
    input  logic                         cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]    addr,
    input  logic [DATA_BITWIDTH-1:0]     wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
    output logic [DATA_BITWIDTH-1:0]     rd_data,
    output logic                         rd_data_valid,
    output logic                         busy,
    output logic [DEPTH_BITWIDTH-1:0]    sram_addr,
    output logic [DATA_BITWIDTH/8-1:0]   sram_we,
    output logic [DATA_BITWIDTH-1:0]     sram_wr_data,
    input  logic [DATA_BITWIDTH-1:0]     sram_rd_data
);

    localparam int NB = DATA_BITWIDTH / 8;
    localparam int BW = $clog2(BURST_COUNT) + 1;
    localparam int WW = $clog2(CYCLES_BEFORE_DATA_READY) + 1;
`ifdef BURST_SRAM_BRIDGE_LATENCY_PAD_EN
    localparam logic [WW-1:0] WAIT_LAST = WW'(CYCLES_BEFORE_DATA_READY - 2);
`else
    localparam logic [WW-1:0] WAIT_LAST = '0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ} state_t;

    state_t                      state_q, state_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [WW-1:0]               wait_q, wait_d;
    logic [DEPTH_BITWIDTH-1:0]   saddr_q, saddr_d;
    logic [NB-1:0]               swe_q, swe_d;
    logic [DATA_BITWIDTH-1:0]    swdata_q, swdata_d;
    logic [DATA_BITWIDTH-1:0]    rdata_q, rdata_d;
    logic                        rvalid_q, rvalid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            wait_q   <= '0;
            saddr_q  <= '0;
            swe_q    <= '0;
            swdata_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            saddr_q  <= saddr_d;
            swe_q    <= swe_d;
            swdata_q <= swdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        saddr_d  = saddr_q;
        swe_d    = '0;
        swdata_d = swdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_en) begin
                    saddr_d = addr;
                    if (cmd) begin
                        swe_d    = ~data_mask;
                        swdata_d = wr_data;
                        beat_d   = BW'(1);
                        state_d  = WRITE;
                    end else begin
                        wait_d  = '0;
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                // beat_q == BURST_COUNT is the drain cycle while the last beat commits
                if (beat_q == BW'(BURST_COUNT)) begin
                    state_d = IDLE;
                end else begin
                    swe_d    = ~data_mask;
                    swdata_d = wr_data;
                    saddr_d  = saddr_q + 1'b1;
                    beat_d   = beat_q + 1'b1;
                end
            end
            READ_WAIT: begin
                // beat-0 address is held here; advancing now lines beat 1 up behind it
                if (wait_q == WAIT_LAST) begin
                    saddr_d = saddr_q + 1'b1;
                    beat_d  = '0;
                    state_d = READ;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            READ: begin
                rdata_d  = sram_rd_data;
                rvalid_d = 1'b1;
                saddr_d  = saddr_q + 1'b1;
                if (beat_q == BW'(BURST_COUNT - 1)) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_data       = rdata_q;
    assign rd_data_valid = rvalid_q;
    assign busy          = (state_q != IDLE);
    assign sram_addr     = saddr_q;
    assign sram_we       = swe_q;
    assign sram_wr_data  = swdata_q;

endmodule

// File: tb/tb_burst_sram_bridge.sv
// Scoreboard bench for burst_sram_bridge with a behavioural byte-enable SRAM attached.
module tb_burst_sram_bridge;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int BC = 4;
`ifdef BURST_SRAM_BRIDGE_LATENCY_PAD_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd = 1'b0;
    logic          cmd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [7:0]    data_mask = '0;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          busy;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_we;
    logic [DW-1:0] sram_wr_data;
    logic [DW-1:0] sram_rd_data = '0;

    logic [DW-1:0] mem [256];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    burst_sram_bridge #(
        .DATA_BITWIDTH(DW),
        .DEPTH_BITWIDTH(AW),
        .BURST_COUNT(BC),
        .CYCLES_BEFORE_DATA_READY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cmd),
        .cmd_en(cmd_en),
        .addr(addr),
        .wr_data(wr_data),
        .data_mask(data_mask),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .busy(busy),
        .sram_addr(sram_addr),
        .sram_we(sram_we),
        .sram_wr_data(sram_wr_data),
        .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wr_data[b*8 +: 8];
        sram_rd_data <= mem[sram_addr];
    end

    // Monitor: every presented beat must match the head of the scoreboard in data and edge index.
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat got=%h at_edge=%0d exp=none", rd_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rd_data !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL read_beat got=%h at_edge=%0d exp=%h at_edge=%0d",
                             rd_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [4*DW-1:0] d, input logic [31:0] m);
        int n;
        cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = d[63:0]; data_mask = m[7:0];
        @(posedge clk); #1;
        cmd_en = 1'b0;
        n = 0;
        for (int j = 1; j < 64; j++) begin
            if (!busy) break;
            n++;
            if (j < BC) begin
                wr_data   = d[j*64 +: 64];
                data_mask = m[j*8 +: 8];
            end
            @(posedge clk); #1;
        end
        check("wr_busy_cycles", DW'(n), DW'(BC));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [4*DW-1:0] exp, input bit poke);
        int k, n;
        cmd = 1'b0; cmd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        k = cyc;
        cmd_en = 1'b0;
        for (int i = 0; i < BC; i++) sb.push_back('{exp[i*64 +: 64], k + LAT + i});
        n = 0;
        for (int j = 0; j < 64; j++) begin
            if (!busy) break;
            n++;
            if (poke) begin
                cmd = 1'b1; cmd_en = 1'b1; addr = '0; wr_data = '1; data_mask = '0;
                check("no_we_during_read", DW'(sram_we), '0);
            end
            @(posedge clk); #1;
        end
        cmd_en = 1'b0;
        check("rd_busy_cycles", DW'(n), DW'(LAT + BC - 1));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = {8{8'(i)}};

        #2;
        check("rst_rd_valid", DW'(rd_data_valid), '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_sram_we", DW'(sram_we), '0);
        check("rst_sram_addr", DW'(sram_addr), '0);
        check("rst_sram_wr_data", sram_wr_data, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_write(8'd8, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'h0);
        check("mem8", mem[8], 64'h1111_1111_1111_1111);
        check("mem9", mem[9], 64'h2222_2222_2222_2222);
        check("mem10", mem[10], 64'h3333_3333_3333_3333);
        check("mem11", mem[11], 64'h4444_4444_4444_4444);

        do_read(8'd8, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);

        do_write(8'd9, {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555,
                        64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF}, 32'h000F_FFF0);
        check("mask_mem9", mem[9], 64'h2222_2222_FFFF_FFFF);
        check("allmask_mem10", mem[10], 64'h3333_3333_3333_3333);
        check("mask_mem11", mem[11], 64'h5555_5555_4444_4444);
        check("mem12", mem[12], 64'h6666_6666_6666_6666);

        do_read(8'd9, {64'h6666_6666_6666_6666, 64'h5555_5555_4444_4444,
                       64'h3333_3333_3333_3333, 64'h2222_2222_FFFF_FFFF}, 1'b0);

        do_read(8'd254, {64'h0101_0101_0101_0101, 64'h0000_0000_0000_0000,
                         64'hFFFF_FFFF_FFFF_FFFF, 64'hFEFE_FEFE_FEFE_FEFE}, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("poke_mem0_untouched", mem[0], 64'h0);

        // Abort a read after two beats have been presented.
        cmd = 1'b0; cmd_en = 1'b1; addr = 8'd8;
        @(posedge clk); #1;
        k = cyc;
        cmd_en = 1'b0;
        sb.push_back('{64'h1111_1111_1111_1111, k + LAT});
        sb.push_back('{64'h2222_2222_FFFF_FFFF, k + LAT + 1});
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk); #1;
        check("beats_before_abort", DW'(sb.size()), '0);
        rst = 1'b1;
        #1;
        check("abort_rd_valid", DW'(rd_data_valid), '0);
        check("abort_rd_data", rd_data, '0);
        check("abort_busy", DW'(busy), '0);
        check("abort_sram_we", DW'(sram_we), '0);
        check("abort_sram_addr", DW'(sram_addr), '0);
        check("abort_sram_wr_data", sram_wr_data, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk); #1;

        do_read(8'd8, {64'h5555_5555_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_FFFF_FFFF, 64'h1111_1111_1111_1111}, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("beats_outstanding", DW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
